// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters, with bounded
// burst hold, a registered issue stage and a tag pipeline that labels read returns.
module ram_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_WIDTH     = 2,
    parameter int DATA_WIDTH   = 36,
    parameter int ADDR_WIDTH   = 14,
    parameter int READ_LATENCY = 11,
    parameter int BURST_LEN    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic                             ram_en,
    output logic                             ram_we,
    output logic [ADDR_WIDTH-1:0]            ram_addr,
    output logic [DATA_WIDTH-1:0]            ram_din,
    input  logic [DATA_WIDTH-1:0]            ram_dout,
    input  logic                             ram_dout_valid,
    output logic                             rsp_valid,
    output logic [ID_WIDTH-1:0]              rsp_id,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             err_sync
);

    localparam int BCNT_W = $clog2(BURST_LEN + 1);

    logic [ID_WIDTH-1:0]     ptr;
    logic [ID_WIDTH-1:0]     hold_id;
    logic [ID_WIDTH-1:0]     gnt_id;
    logic [ID_WIDTH-1:0]     cand;
    logic [ID_WIDTH-1:0]     issue_id;
    logic [BCNT_W-1:0]       bcnt;
    logic [BCNT_W-1:0]       bcnt_inc;
    logic                    gnt_any;
    logic                    xfer;
    logic [READ_LATENCY-1:0] tag_vld_p;
    logic [ID_WIDTH-1:0]     tag_id_p [READ_LATENCY];

    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] i);
        if (int'(i) >= NUM_REQ - 1) return '0;
        return i + 1'b1;
    endfunction

    // A nonzero bcnt means the holder transferred last cycle with burst budget left.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = hold_id;
        cand    = ptr;
        if (bcnt != '0 && req_valid[hold_id]) begin
            gnt_any = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!gnt_any && req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_id  = cand;
                end
                cand = next_id(cand);
            end
        end
    end

    assign xfer     = gnt_any & ~rst;
    assign bcnt_inc = (gnt_id == hold_id) ? bcnt + 1'b1 : BCNT_W'(1);

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            hold_id <= '0;
            bcnt    <= '0;
        end else if (xfer) begin
            hold_id <= gnt_id;
            if (bcnt_inc == BCNT_W'(BURST_LEN)) begin
                ptr  <= next_id(gnt_id);
                bcnt <= '0;
            end else begin
                bcnt <= bcnt_inc;
                // Holder dropped out mid-burst: fairness resumes after it.
                if (gnt_id != hold_id && bcnt != '0) ptr <= next_id(hold_id);
            end
        end else begin
            bcnt <= '0;
            if (bcnt != '0) ptr <= next_id(hold_id);
        end
    end

    // ---- issue stage: one registered RAM access per transferred beat ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_en <= xfer;
            ram_we <= xfer & req_we[gnt_id];
            if (xfer) begin
                ram_addr <= req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
                ram_din  <= req_wdata[gnt_id*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) issue_id <= gnt_id;
    end

    // ---- tag pipeline: READ_LATENCY stages aligned to the RAM read path ----
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_p <= '0;
        end else begin
            tag_vld_p[0] <= ram_en & ~ram_we;
            for (int s = 1; s < READ_LATENCY; s++) tag_vld_p[s] <= tag_vld_p[s-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_id_p[0] <= issue_id;
        for (int s = 1; s < READ_LATENCY; s++) tag_id_p[s] <= tag_id_p[s-1];
    end

    // ---- response / error: RAM output paired with the tail tag ----
    assign rsp_valid = ram_dout_valid;
    assign rsp_data  = ram_dout;
    assign rsp_id    = tag_id_p[READ_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sync <= 1'b0;
        end else if (ram_dout_valid != tag_vld_p[READ_LATENCY-1]) begin
            err_sync <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a BURST_LEN=4 instance and a BURST_LEN=1
// instance share stimulus, each backed by a small latency-matched RAM model.
module tb_ram_port_arbiter;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int DW = 36;
    localparam int AW = 14;
    localparam int RL = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_we    = '0;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic             inject = 1'b0;

    logic [NR-1:0] ready, rr_ready;
    logic          ram_en, ram_we, rr_ram_en, rr_ram_we;
    logic [AW-1:0] ram_addr, rr_ram_addr;
    logic [DW-1:0] ram_din, rr_ram_din, ram_dout, rr_ram_dout;
    logic          ram_dout_valid, rr_ram_dout_valid;
    logic          rsp_valid, rr_rsp_valid;
    logic [IW-1:0] rsp_id, rr_rsp_id;
    logic [DW-1:0] rsp_data, rr_rsp_data;
    logic          err_sync, rr_err_sync;

    ram_port_arbiter #(
        .NUM_REQ(NR), .ID_WIDTH(IW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .READ_LATENCY(RL), .BURST_LEN(4)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_dout_valid(ram_dout_valid),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .err_sync(err_sync)
    );

    ram_port_arbiter #(
        .NUM_REQ(NR), .ID_WIDTH(IW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .READ_LATENCY(RL), .BURST_LEN(1)
    ) u_rr (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .ram_en(rr_ram_en), .ram_we(rr_ram_we), .ram_addr(rr_ram_addr), .ram_din(rr_ram_din),
        .ram_dout(rr_ram_dout), .ram_dout_valid(rr_ram_dout_valid),
        .rsp_valid(rr_rsp_valid), .rsp_id(rr_rsp_id), .rsp_data(rr_rsp_data), .err_sync(rr_err_sync)
    );

    // RAM model for the burst instance: write-first, RL cycles from enable to valid.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [RL-1:0] m_vld = '0;
    logic [DW-1:0] m_dat [RL];
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_din;
        m_vld    <= {m_vld[RL-2:0], ram_en & ~ram_we};
        m_dat[0] <= (ram_en && ram_we) ? ram_din : mem[ram_addr];
        for (int s = 1; s < RL; s++) m_dat[s] <= m_dat[s-1];
    end
    assign ram_dout       = m_dat[RL-1];
    assign ram_dout_valid = m_vld[RL-1] | inject;

    logic [RL-1:0] rr_vld = '0;
    always @(posedge clk) rr_vld <= {rr_vld[RL-2:0], rr_ram_en & ~rr_ram_we};
    assign rr_ram_dout       = '0;
    assign rr_ram_dout_valid = rr_vld[RL-1];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [NR-1:0] v, input logic [NR-1:0] we);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_we    = we;
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, '0, '0);
        step(1'b1, '0, '0);
    endtask

    task automatic drain();
        repeat (14) step(1'b0, '0, '0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = AW'(32'h100 + i);
            req_wdata[i*DW +: DW] = DW'(32'h1000 + i);
        end

        // reset with requests pending: no grants, registers cleared
        step(1'b1, 4'hF, 4'h0);
        step(1'b1, 4'hF, 4'h0);
        check("rst_ready", ready, 0);
        check("rst_rr_ready", rr_ready, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        check("rst_err", err_sync, 0);
        check("rst_rsp_valid", rsp_valid, 0);

        // pure round robin with 4 readers
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 4'hF, 4'h0);
            check("rr_grant", rr_ready, 64'd1 << (k % 4));
            check("rr_ram_en", rr_ram_en, (k >= 1) ? 1 : 0);
            if (k == 11) check("rr_rsp_early", rr_rsp_valid, 0);
            if (k >= 12) begin
                check("rr_rsp_valid", rr_rsp_valid, 1);
                check("rr_rsp_id", rr_rsp_id, (k - 12) % 4);
            end
        end
        drain();
        do_reset();

        // burst hold between requesters 1 and 2
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 4'b0110, 4'h0);
            check("burst_grant", ready, (((k / 4) % 2) == 0) ? 2 : 4);
        end
        drain();
        do_reset();

        // burst break: 0 drops after 2 beats, 3 takes over with a fresh count
        step(1'b0, 4'b1001, 4'hF); check("brkA_g0", ready, 1);
        step(1'b0, 4'b1001, 4'hF); check("brkA_g1", ready, 1);
        step(1'b0, 4'b1000, 4'hF); check("brkA_g2", ready, 8);
        for (int k = 3; k < 6; k++) begin
            step(1'b0, 4'b1001, 4'hF);
            check("brkA_hold3", ready, 8);
        end
        step(1'b0, 4'b1001, 4'hF); check("brkA_back0", ready, 1);
        do_reset();

        // burst break: pointer moves past the dropped holder
        step(1'b0, 4'b1001, 4'hF); check("brkB_g0", ready, 1);
        step(1'b0, 4'b1001, 4'hF); check("brkB_g1", ready, 1);
        step(1'b0, 4'b1000, 4'hF); check("brkB_g2", ready, 8);
        step(1'b0, 4'b0011, 4'hF); check("brkB_ptr1", ready, 2);
        do_reset();

        // write then read through requester 2
        req_addr[2*AW +: AW]  = 14'h0010;
        req_wdata[2*DW +: DW] = 36'hABCDE;
        step(1'b0, 4'b0100, 4'b0100);
        check("wr_grant", ready, 4);
        step(1'b0, 4'b0100, 4'b0000);
        check("rd_grant", ready, 4);
        check("wr_ram_en", ram_en, 1);
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 14'h0010);
        check("wr_ram_din", ram_din, 36'hABCDE);
        step(1'b0, 4'b0000, 4'b0000);
        check("rd_ram_en", ram_en, 1);
        check("rd_ram_we", ram_we, 0);
        check("rd_ram_addr", ram_addr, 14'h0010);
        n = 0;
        for (int k = 3; k <= 20; k++) begin
            step(1'b0, 4'b0000, 4'b0000);
            if (rsp_valid) begin
                n++;
                check("wr_rsp_cycle", k, 13);
                check("wr_rsp_id", rsp_id, 2);
                check("wr_rsp_data", rsp_data, 36'hABCDE);
            end
        end
        check("wr_rsp_count", n, 1);
        check("wr_err", err_sync, 0);

        // spurious valid strobe makes err_sync stick until reset
        step(1'b0, '0, '0);
        inject = 1'b1;
        check("mm_err_before", err_sync, 0);
        step(1'b0, '0, '0);
        inject = 1'b0;
        check("mm_err_set", err_sync, 1);
        repeat (4) step(1'b0, '0, '0);
        check("mm_err_sticky", err_sync, 1);
        do_reset();
        check("mm_err_cleared", err_sync, 0);

        // reset in the middle of a read stream
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 4'hF, 4'h0);
            check("mid_grant", ready, (k < 4) ? 1 : 2);
        end
        step(1'b1, 4'hF, 4'h0);
        check("mid_rst_ready", ready, 0);
        step(1'b0, 4'hF, 4'h0);
        check("mid_ram_en_off", ram_en, 0);
        check("mid_restart0", ready, 1);
        step(1'b0, 4'hF, 4'h0);
        check("mid_hold0", ready, 1);
        check("mid_ram_en_on", ram_en, 1);
        drain();
        check("mid_stale_err", err_sync, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one port of the team's true-dual-port RAM (port A or B, configured with `RAM_BEHAVIOR` "read_first" or "write_first") between `NUM_REQ` requesters. It issues one registered RAM access per cycle. A requester may hold the port for a bounded burst. Read data is returned tagged with the requester ID through a tag pipeline aligned to the RAM read latency. A sticky error flags any mismatch between the tag pipeline and the RAM's output-valid strobe.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ID_WIDTH`, 2: width of requester ID; must satisfy 2**ID_WIDTH >= NUM_REQ.
- `DATA_WIDTH`, 36: RAM word width.
- `ADDR_WIDTH`, 14: RAM address width.
- `READ_LATENCY`, 11: cycles from the `ram_en` cycle to `ram_dout_valid`; set to the RAM's `DOUT_PIPE_NUMBER` + 1; >= 1.
- `BURST_LEN`, 4: maximum consecutive grants to one requester, >= 1.

Ports:
- `clk`  in  1: single clock for all logic.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: per-requester request.
- `req_ready`  out  NUM_REQ: one-hot grant; a beat transfers when `req_valid[i]` and `req_ready[i]` are both high.
- `req_we`  in  NUM_REQ: 1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH: packed; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  NUM_REQ*DATA_WIDTH: packed, same slicing scheme.
- `ram_en`, `ram_we`  out  1: RAM port enable and write enable.
- `ram_addr`  out  ADDR_WIDTH: RAM port address.
- `ram_din`  out  DATA_WIDTH: RAM port write data.
- `ram_dout`  in  DATA_WIDTH: RAM port read data.
- `ram_dout_valid`  in  1: RAM port output-valid strobe.
- `rsp_valid`  out  1: read response valid; no backpressure.
- `rsp_id`  out  ID_WIDTH: requester that issued the read.
- `rsp_data`  out  DATA_WIDTH: read data.
- `err_sync`  out  1: sticky tag/valid mismatch flag.

## Operation
**Arbitration**
- Combinational from `req_valid`, pointer `ptr`, burst holder `hold_id` and count `bcnt`.
- Burst hold applies if, last cycle, requester h was granted and transferred, `req_valid[h]` is still high, and `bcnt` < `BURST_LEN`. In that case requester h is granted again.
- Otherwise the grant goes to the first valid requester scanning `ptr`, `ptr`+1, … modulo `NUM_REQ`.
- A grant is only a handshake if `req_valid` is high. `req_ready` is never high for a requester whose `req_valid` is low.

**State update**
- On a transfer to requester i:
  - `bcnt` becomes `bcnt`+1 if i == `hold_id`, else 1.
  - `hold_id` becomes i.
  - If the new `bcnt` == `BURST_LEN`, `ptr` becomes (i+1) mod `NUM_REQ` and `bcnt` clears to 0.
- On a cycle with no transfer, `bcnt` clears to 0 and `ptr` becomes (`hold_id`+1) mod `NUM_REQ` (only if a burst was active).
- A switch to a different requester after a partial burst also sets `ptr` to (old `hold_id`+1).

**Issue register**
- The transferred beat's fields go to `ram_en`=1, `ram_we`, `ram_addr` and `ram_din` on the next edge.
- With no transfer, `ram_en`=0 and `ram_we`=0; `ram_addr` and `ram_din` hold their values.

**Tag pipeline**
- `READ_LATENCY` stages, each holding {valid, id}. It shifts every cycle.
- Stage 0 loads {`ram_en` & ~`ram_we`, id of the issued beat}.

**Response**
- `rsp_valid` = `ram_dout_valid`.
- `rsp_data` = `ram_dout` (combinational passthrough).
- `rsp_id` = tail stage id.

**Error**
- `err_sync` sets when `ram_dout_valid` != tail valid. It stays set until `rst`.

## Timing
- **Reset values:** `req_ready`=0, `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, all tag valids 0, `ptr`=0, `hold_id`=0, `bcnt`=0, `err_sync`=0.
- **During reset:** `req_ready` is forced to 0 while `rst` is high.
- **Reset mid-operation:** `rst` asserted mid-burst or with reads in flight discards all tags. Any RAM valid strobes that still arrive afterwards set `err_sync` after reset deasserts. Callers must let the RAM pipe drain before releasing `rst`.
- **Issue latency:** request handshake at cycle t → `ram_en` at t+1.
- **Read latency:** read handshake at t → `rsp_valid` at t+1+`READ_LATENCY`, with `rsp_id` equal to the requester index.
- **Throughput:** 1 beat/cycle sustained. Back-to-back reads from different requesters return in issue order.
- **Writes:** produce no response and no tag. A write followed by a read to the same address returns the new data (ordered RAM port).
- **`BURST_LEN`=1:** pure round-robin.
- **Single active requester:** re-granted every cycle, since `ptr` wraps back to it.

## Test plan
- **Round-robin reads:** reset, then all 4 `req_valid` high with reads, `BURST_LEN`=1. Required: grant order 0,1,2,3,0,…. `ram_en` asserts the cycle after each grant. Responses arrive 12 cycles (1+11) after handshake with `rsp_id` 0,1,2,3.
- **Burst hold:** `BURST_LEN`=4, requesters 1 and 2 held valid. Required: requester 1 receives grants 4 cycles in a row, then requester 2 receives grants 4 cycles in a row, then control returns to 1.
- **Burst break:** requester 0 drops valid after 2 beats while requester 3 is waiting. Required: requester 3 is granted next cycle; `ptr` becomes 1; `bcnt` restarts at 1.
- **Write then read:** requester 2 writes 0xABCDE to address 0x0010, then reads 0x0010. Required: `ram_we`=1 and then `ram_we`=0 on consecutive cycles; one response only, with `rsp_id`=2 and `rsp_data`=0xABCDE.
- **Mismatch:** inject a spurious `ram_dout_valid` pulse with no read outstanding. Required: `err_sync`=1 next cycle and it remains 1 until `rst`.
- **Reset mid-burst:** assert `rst` for 1 cycle during a 4-requester read stream. Required: `ram_en`=0 and `req_ready`=0 the cycle after; arbitration restarts at requester 0.
